// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle signed multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = MD_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } md_state_t;

    typedef enum logic {
        OPK_MULT = 1'b0,
        OPK_DIV  = 1'b1
    } opk_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude loop: a single 33-bit add/subtract shared
// between the multiply accumulate and the restoring divide trial, followed
// by the shift that each algorithm needs.
module muldiv_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  opk_t             opk,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    input  logic             add_en,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic             sub;
    logic [WIDTH:0]   lhs;
    logic [WIDTH:0]   rhs;
    logic [WIDTH:0]   sum;

    // Shared adder: multiply adds the multiplicand into the upper half,
    // divide subtracts the divisor from the left-shifted remainder.
    always_comb begin
        sub = (opk == OPK_DIV);
        lhs = '0;
        rhs = '0;
        if (sub) begin
            lhs = {acc_hi, acc_lo[WIDTH-1]};
            rhs = {1'b0, operand};
        end else begin
            lhs = {1'b0, acc_hi};
            rhs = add_en ? {1'b0, operand} : '0;
        end
        sum = lhs + (rhs ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
    end

    // Post-add shift: right shift with carry for multiply, restore-or-keep
    // with quotient bit insertion for divide.
    always_comb begin
        nxt_hi = '0;
        nxt_lo = '0;
        if (sub) begin
            if (!sum[WIDTH]) begin
                nxt_hi = sum[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = lhs[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Signed MULT/DIV sequencer owning the HI/LO pair. One shared iteration
// unit, one start/busy/done handshake.
//
// state    | meaning
// ST_IDLE  | waiting for start_mult / start_div
// ST_MULT  | shift-add iterations on operand magnitudes
// ST_DIV   | restoring divide iterations on operand magnitudes
// ST_FIXUP | sign correction, HI/LO commit
// ST_DONE  | one-cycle done (and div_zero) pulse
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    md_state_t          state;
    opk_t               opk;
    logic               res_sign;
    logic               rem_sign;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes; the most negative value maps to unsigned 2^(W-1).
    always_comb begin
        a_mag = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
        b_mag = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
        prod  = {acc_hi, acc_lo};
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .opk     (opk),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .add_en  (mplier[0]),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // Sequencer FSM, iteration down-counter and HI/LO commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            opk      <= OPK_MULT;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            mplier   <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_mult) begin
                        operand  <= a_mag;
                        mplier   <= b_mag;
                        acc_hi   <= '0;
                        acc_lo   <= '0;
                        res_sign <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        opk      <= OPK_MULT;
                        cnt      <= CW'(ITERS - 1);
                        state    <= ST_MULT;
                        busy     <= 1'b1;
                    end else if (start_div) begin
                        if (op_b != '0) begin
                            operand  <= b_mag;
                            mplier   <= '0;
                            acc_hi   <= '0;
                            acc_lo   <= a_mag;
                            res_sign <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            rem_sign <= op_a[WIDTH-1];
                            opk      <= OPK_DIV;
                            cnt      <= CW'(ITERS - 1);
                            state    <= ST_DIV;
                        end else begin
                            // Zero divisor: skip the loop, leave HI/LO alone.
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end
                        busy <= 1'b1;
                    end
                end
                ST_MULT, ST_DIV: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (opk == OPK_MULT) begin
                        mplier <= mplier >> 1;
                    end
                    if (cnt == '0) begin
                        state <= ST_FIXUP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_FIXUP: begin
                    if (opk == OPK_MULT) begin
                        {hi_out, lo_out} <= res_sign ? (~prod + 1'b1) : prod;
                    end else begin
                        lo_out <= res_sign ? (~acc_lo + 1'b1) : acc_lo;
                        hi_out <= rem_sign ? (~acc_hi + 1'b1) : acc_hi;
                    end
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus hand-written
// multi-cycle sequences, results checked through a scoreboard queue.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .WIDTH (32),
        .ITERS (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done with empty scoreboard at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_hi", 64'(hi_out), 64'(mon_e.hi));
                check("result_lo", 64'(lo_out), 64'(mon_e.lo));
                check("result_div_zero", 64'(div_zero), 64'(mon_e.dz));
            end
        end
    end

    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input int exp_lat, input int inject_at, input string tag);
        int  lat;
        int  busy_n;
        int  n0;
        bit  seen;
        exp_t e;
        @(negedge clk);
        start_mult = m;
        start_div  = d;
        op_a       = a;
        op_b       = b;
        e.hi = eh;
        e.lo = el;
        e.dz = edz;
        sb_q.push_back(e);
        n0     = done_cnt;
        lat    = 0;
        busy_n = 0;
        seen   = 0;
        for (int k = 1; k <= 80 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_mult = 1'b0;
                start_div  = 1'b0;
            end
            if (inject_at != 0 && k == inject_at) begin
                start_div = 1'b1;
                op_a      = 32'd50;
                op_b      = 32'd3;
            end
            if (inject_at != 0 && k == inject_at + 1) start_div = 1'b0;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                seen = 1;
                lat  = k;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done within 80 cycles, want done", tag);
        end else begin
            check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        end
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        check({tag, "_single_done"}, 64'(done_cnt - n0), 64'(1));
    endtask

    vec_t vecs[13];
    int   n0_rst;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[1]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[3]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[4]  = '{1'b0, 1'b1, 32'h5678_1234, 32'h0001_0000, 32'h0000_1234, 32'h0000_5678, 1'b0, 34};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 1'b1, 1};
        vecs[6]  = '{1'b1, 1'b0, 32'd100,       32'd200,       32'h0000_0000, 32'h0000_4E20, 1'b0, 34};
        vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};
        vecs[8]  = '{1'b0, 1'b1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 34};
        vecs[9]  = '{1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[10] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 34};
        vecs[11] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 34};

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_div_zero", 64'(div_zero), 64'(0));
        check("reset_hi", 64'(hi_out), 64'(0));
        check("reset_lo", 64'(lo_out), 64'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat, 0, $sformatf("vec%0d", i));
        end

        // Both starts together: multiply wins, single done.
        run_op(1'b1, 1'b1, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 34, 0, "both_starts");

        // Divide request pulsed while a multiply is busy is dropped.
        run_op(1'b1, 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 34, 5, "busy_start_div");
        repeat (40) @(negedge clk);
        check("busy_start_div_no_extra", 64'(sb_q.size()), 64'(0));

        // Reset ten cycles into a divide: aborted, no done, HI/LO cleared.
        check("pre_reset_lo_nonzero", 64'(lo_out == 32'd0), 64'(0));
        @(negedge clk);
        start_div = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd7;
        n0_rst    = done_cnt;
        @(negedge clk);
        start_div = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_busy", 64'(busy), 64'(0));
        check("mid_reset_hi", 64'(hi_out), 64'(0));
        check("mid_reset_lo", 64'(lo_out), 64'(0));
        check("mid_reset_done", 64'(done), 64'(0));
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_reset_no_done", 64'(done_cnt), 64'(n0_rst));

        run_op(1'b1, 1'b0, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEE, 1'b0, 34, 0, "post_reset_mult");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
